// File: rtl/fft_bfly_r2.sv
// First radix-2 DIT butterfly stage (twiddle 1): emits A+B then A-B for each input pair.
// Optional build macro FFT_BFLY_SCALE_EN halves every result so overflow is impossible.
module fft_bfly_r2 #(
  parameter int K  = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  input  logic          ready_i,
  output logic          last_o,
  output logic          ovf_o
);

  localparam int H = DW / 2;

  typedef enum logic [1:0] {S_A, S_B, S_SUM, S_DIF} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [K-1:0]  cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          in_xfer_s, out_xfer_s;
  logic [H:0]    sum_re_s, sum_im_s, dif_re_s, dif_im_s;
  logic [DW-1:0] sum_w_s, dif_w_s;
  logic          ovf_sum_s, ovf_dif_s;

  // Reduce an H+1 bit component result to H bits (scaled or wrapped).
  function automatic logic [H-1:0] reduce_c(input logic [H:0] v);
`ifdef FFT_BFLY_SCALE_EN
    return v[H:1];
`else
    return v[H-1:0];
`endif
  endfunction

  // True when an H+1 bit result does not fit in H signed bits.
  function automatic logic ovf_c(input logic [H:0] v);
    return v[H] ^ v[H-1];
  endfunction

  assign ready_o    = (state_q == S_A) || (state_q == S_B);
  assign valid_o    = (state_q == S_SUM) || (state_q == S_DIF);
  assign in_xfer_s  = valid_i && ready_o;
  assign out_xfer_s = valid_o && ready_i;

  assign sum_re_s = {a_q[DW-1], a_q[DW-1:H]} + {b_q[DW-1], b_q[DW-1:H]};
  assign dif_re_s = {a_q[DW-1], a_q[DW-1:H]} - {b_q[DW-1], b_q[DW-1:H]};
  assign sum_im_s = {a_q[H-1], a_q[H-1:0]} + {b_q[H-1], b_q[H-1:0]};
  assign dif_im_s = {a_q[H-1], a_q[H-1:0]} - {b_q[H-1], b_q[H-1:0]};

  assign sum_w_s   = {reduce_c(sum_re_s), reduce_c(sum_im_s)};
  assign dif_w_s   = {reduce_c(dif_re_s), reduce_c(dif_im_s)};
  assign ovf_sum_s = ovf_c(sum_re_s) || ovf_c(sum_im_s);
  assign ovf_dif_s = ovf_c(dif_re_s) || ovf_c(dif_im_s);

  assign data_o = (state_q == S_SUM) ? sum_w_s :
                  (state_q == S_DIF) ? dif_w_s : {DW{1'b0}};
  assign last_o = valid_o && (cnt_q == {K{1'b1}});
  assign ovf_o  = ovf_q;

  // Next-state logic: pair capture, output sequencing, frame counter, sticky overflow.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_A: begin
        if (in_xfer_s) begin
          a_d     = data_i;
          state_d = S_B;
        end else begin
          state_d = S_A;
        end
      end
      S_B: begin
        if (in_xfer_s) begin
          b_d     = data_i;
          state_d = S_SUM;
        end else begin
          state_d = S_B;
        end
      end
      S_SUM: begin
        if (out_xfer_s) begin
          cnt_d   = cnt_q + K'(1);
          ovf_d   = ovf_q || ovf_sum_s;
          state_d = S_DIF;
        end else begin
          state_d = S_SUM;
        end
      end
      S_DIF: begin
        if (out_xfer_s) begin
          cnt_d   = cnt_q + K'(1);
          ovf_d   = ovf_q || ovf_dif_s;
          state_d = S_A;
        end else begin
          state_d = S_DIF;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
`ifdef FFT_BFLY_SCALE_EN
    ovf_d = 1'b0;
`endif
  end

  // State register; reset wins over any simultaneous transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_A;
      a_q     <= {DW{1'b0}};
      b_q     <= {DW{1'b0}};
      cnt_q   <= {K{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Directed self-checking bench for fft_bfly_r2 (expectations follow FFT_BFLY_SCALE_EN).
module tb_fft_bfly_r2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = 32'h0;
  logic        ready_i = 1'b0;
  logic        ready_o, valid_o, last_o, ovf_o;
  logic [31:0] data_o;

  int checks = 0;
  int failures = 0;

  fft_bfly_r2 #(.K(10), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .last_o(last_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send(input logic [31:0] w);
    int n = 0;
    valid_i = 1'b1;
    data_i  = w;
    while (!ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    data_i  = 32'h0;
  endtask

  task automatic recv(input string tag, input logic [31:0] exp, input logic exp_last);
    int n = 0;
    ready_i = 1'b1;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk(tag, data_o, exp);
    chk({tag, "_last"}, {31'd0, last_o}, {31'd0, exp_last});
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef FFT_BFLY_SCALE_EN
  localparam logic [31:0] E_BS = 32'h003C_001E, E_BD = 32'h0028_0014;
  localparam logic [31:0] E_OS = 32'h4000_0000, E_OD = 32'h3FFF_0000;
  localparam logic        E_OVF = 1'b0;
  localparam logic [31:0] E_PS = 32'h0009_0010, E_PD = 32'h0006_000F;
  localparam logic [31:0] E_RS = 32'h0001_0000, E_RD = 32'hFFFF_0000;
`else
  localparam logic [31:0] E_BS = 32'h0078_003C, E_BD = 32'h0050_0028;
  localparam logic [31:0] E_OS = 32'h8000_0000, E_OD = 32'h7FFE_0000;
  localparam logic        E_OVF = 1'b1;
  localparam logic [31:0] E_PS = 32'h0013_0021, E_PD = 32'h000D_001F;
  localparam logic [31:0] E_RS = 32'h0003_0000, E_RD = 32'hFFFF_0000;
`endif

  initial begin
    logic [31:0] exp_s;
    @(negedge clk);
    do_reset();
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);

    // Basic pair and one-cycle latency
    send(32'h0064_0032);
    chk("b_ready_after_a", {31'd0, ready_o}, 32'd1);
    chk("b_idle_data", data_o, 32'h0);
    send(32'h0014_000A);
    chk("b_latency_valid", {31'd0, valid_o}, 32'd1);
    chk("b_latency_ready", {31'd0, ready_o}, 32'd0);
    recv("b_sum", E_BS, 1'b0);
    recv("b_dif", E_BD, 1'b0);
    chk("b_ovf", {31'd0, ovf_o}, 32'd0);

    // Overflow and sticky flag
    send(32'h7FFF_0000);
    send(32'h0001_0000);
    chk("o_ovf_before", {31'd0, ovf_o}, 32'd0);
    recv("o_sum", E_OS, 1'b0);
    chk("o_ovf_after_sum", {31'd0, ovf_o}, {31'd0, E_OVF});
    recv("o_dif", E_OD, 1'b0);
    repeat (3) @(negedge clk);
    chk("o_ovf_sticky", {31'd0, ovf_o}, {31'd0, E_OVF});
    do_reset();
    chk("o_ovf_cleared", {31'd0, ovf_o}, 32'd0);

    // Backpressure: hold in S_SUM for 5 cycles
    send(32'h0010_0020);
    send(32'h0003_0001);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_data", data_o, E_PS);
      @(negedge clk);
    end
    recv("bp_sum", E_PS, 1'b0);
    recv("bp_dif", E_PD, 1'b0);
    chk("bp_back_to_a", {31'd0, ready_o}, 32'd1);

    // Reset mid-pair discards A
    send(32'h0005_0000);
    do_reset();
    chk("rmp_ready", {31'd0, ready_o}, 32'd1);
    send(32'h0001_0000);
    send(32'h0002_0000);
    recv("rmp_sum", E_RS, 1'b0);
    recv("rmp_dif", E_RD, 1'b0);

    // Reset mid-output, then counter must restart for the frames
    send(32'h0001_0000);
    send(32'h0001_0000);
    recv("rmo_sum", 32'h0002_0000 >> ((E_RS == 32'h0001_0000) ? 1 : 0) & 32'hFFFF_0000, 1'b0);
    do_reset();
    chk("rmo_valid", {31'd0, valid_o}, 32'd0);
    chk("rmo_data", data_o, 32'h0);

    // Two frames of x[i]=i (real part)
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 512; p++) begin
        send({16'(2 * p), 16'h0});
        send({16'(2 * p + 1), 16'h0});
`ifdef FFT_BFLY_SCALE_EN
        exp_s = {16'(2 * p), 16'h0};
`else
        exp_s = {16'(4 * p + 1), 16'h0};
`endif
        recv("fr_sum", exp_s, 1'b0);
        recv("fr_dif", 32'hFFFF_0000, (p == 511));
      end
    end
    chk("fr_ovf", {31'd0, ovf_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
